// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational reads, two synchronous writes,
// optional write-first bypass and hardwired entry 0, plus a one-row-per-cycle clear engine.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              clr_start,
  output logic              busy,
  output logic              wr_drop,
  output logic              wr_conflict
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [DEPTH];

  logic we0_eff;
  logic we1_eff;
  logic conflict;

  // Writes to a hardwired-zero entry 0 are dropped before they can collide.
  always_comb begin
    we0_eff  = we0 && !(R0_ZERO != 0 && wa0 == '0);
    we1_eff  = we1 && !(R0_ZERO != 0 && wa1 == '0);
    conflict = we0_eff && we1_eff && (wa0 == wa1);
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] v;
    v = regs[ra];
    if (BYPASS != 0 && state == IDLE) begin
      if (we1 && wa1 == ra)      v = wd1;
      else if (we0 && wa0 == ra) v = wd0;
    end
    if (R0_ZERO != 0 && ra == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      state       <= IDLE;
      ptr         <= '0;
      busy        <= 1'b0;
      wr_drop     <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      wr_drop     <= 1'b0;
      wr_conflict <= 1'b0;
      case (state)
        IDLE: begin
          // Port 1 is assigned last so it wins an address collision.
          if (we0_eff) regs[wa0] <= wd0;
          if (we1_eff) regs[wa1] <= wd1;
          wr_conflict <= conflict;
          if (clr_start) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          regs[ptr] <= '0;
          wr_drop   <= we0 | we1;
          if (ptr == LAST_ROW) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: one build with hardwired r0 + bypass, one with neither,
// both driven by the same stimulus and compared against an array-based model.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              we0 = 1'b0, we1 = 1'b0, clr_start = 1'b0;
  logic [ADDR_W-1:0] wa0 = '0, wa1 = '0, ra1 = '0, ra2 = '0;
  logic [DATA_W-1:0] wd0 = '0, wd1 = '0;
  logic [DATA_W-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic              busy_a, wr_drop_a, wr_conflict_a;
  logic              busy_b, wr_drop_b, wr_conflict_b;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .clr_start(clr_start), .busy(busy_a), .wr_drop(wr_drop_a), .wr_conflict(wr_conflict_a)
  );

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .clr_start(clr_start), .busy(busy_b), .wr_drop(wr_drop_b), .wr_conflict(wr_conflict_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: contents per build, remaining sweep rows, expected status pulses.
  logic [DATA_W-1:0] ma [DEPTH];
  logic [DATA_W-1:0] mb [DEPTH];
  int   sweep_left = 0;
  int   sweep_row  = 0;
  logic exp_drop   = 1'b0;
  logic exp_conf_a = 1'b0;
  logic exp_conf_b = 1'b0;

  function automatic logic [DATA_W-1:0] exp_rd_a(input logic [ADDR_W-1:0] ra);
    if (ra == '0) return '0;
    if (sweep_left == 0 && we1 && wa1 == ra) return wd1;
    if (sweep_left == 0 && we0 && wa0 == ra) return wd0;
    return ma[ra];
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd_b(input logic [ADDR_W-1:0] ra);
    return mb[ra];
  endfunction

  task automatic model_update();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin ma[i] = '0; mb[i] = '0; end
      sweep_left = 0; sweep_row = 0;
      exp_drop = 1'b0; exp_conf_a = 1'b0; exp_conf_b = 1'b0;
    end else if (sweep_left > 0) begin
      exp_drop = we0 | we1; exp_conf_a = 1'b0; exp_conf_b = 1'b0;
      ma[sweep_row] = '0; mb[sweep_row] = '0;
      sweep_row++; sweep_left--;
    end else begin
      exp_drop   = 1'b0;
      exp_conf_a = we0 && we1 && wa0 == wa1 && wa0 != '0;
      exp_conf_b = we0 && we1 && wa0 == wa1;
      if (we0) begin if (wa0 != '0) ma[wa0] = wd0; mb[wa0] = wd0; end
      if (we1) begin if (wa1 != '0) ma[wa1] = wd1; mb[wa1] = wd1; end
      if (clr_start) begin sweep_left = DEPTH; sweep_row = 0; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0; clr_start = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra1 = '0; ra2 = '0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1'b1; step(); reset = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      ra1 = ADDR_W'(r); ra2 = ADDR_W'(DEPTH - 1 - r); #1;
      vectors++;
      if (rd1_a !== '0 || rd2_a !== '0 || rd1_b !== '0 || rd2_b !== '0) begin
        miscompares++;
        $display("FAIL reset_read ra=%0d got a=%h/%h b=%h/%h want 0", r, rd1_a, rd2_a, rd1_b, rd2_b);
      end
    end
    vectors++;
    if ({busy_a, wr_drop_a, wr_conflict_a, busy_b, wr_drop_b, wr_conflict_b} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_status got %b%b%b %b%b%b want all 0", busy_a, wr_drop_a, wr_conflict_a,
               busy_b, wr_drop_b, wr_conflict_b);
    end
  endtask

  task automatic test_bypass();
    idle_inputs(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5; #1;
    vectors++;
    if (rd1_a !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL bypass_same_cycle got %h want deadbeef", rd1_a);
    end
    vectors++;
    if (rd1_b !== 32'h0) begin
      miscompares++; $display("FAIL nobypass_same_cycle got %h want 0", rd1_b);
    end
    step(); we0 = 1'b0; #1;
    vectors++;
    if (rd1_a !== 32'hDEADBEEF || rd1_b !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL write_next_cycle got a=%h b=%h want deadbeef", rd1_a, rd1_b);
    end
  endtask

  task automatic test_conflict();
    idle_inputs();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra1 = 5'd7; #1;
    vectors++;
    if (rd1_a !== 32'h22) begin
      miscompares++; $display("FAIL bypass_port1_priority got %h want 22", rd1_a);
    end
    step();
    vectors++;
    if (wr_conflict_a !== 1'b1 || wr_conflict_b !== 1'b1) begin
      miscompares++; $display("FAIL conflict_flag got a=%b b=%b want 1", wr_conflict_a, wr_conflict_b);
    end
    idle_inputs(); ra1 = 5'd7; #1;
    vectors++;
    if (rd1_a !== 32'h22 || rd1_b !== 32'h22) begin
      miscompares++; $display("FAIL conflict_winner got a=%h b=%h want 22", rd1_a, rd1_b);
    end
    step();
    vectors++;
    if (wr_conflict_a !== 1'b0 || wr_conflict_b !== 1'b0) begin
      miscompares++; $display("FAIL conflict_pulse_width got a=%b b=%b want 0", wr_conflict_a, wr_conflict_b);
    end
    we0 = 1'b1; we1 = 1'b1; wa0 = '0; wa1 = '0; wd0 = 32'h55; wd1 = 32'h55; ra1 = '0;
    step();
    vectors++;
    if (wr_conflict_a !== 1'b0 || wr_conflict_b !== 1'b1) begin
      miscompares++; $display("FAIL r0_conflict got a=%b b=%b want a=0 b=1", wr_conflict_a, wr_conflict_b);
    end
    idle_inputs(); #1;
    vectors++;
    if (rd1_a !== 32'h0 || rd1_b !== 32'h55) begin
      miscompares++; $display("FAIL r0_read got a=%h b=%h want a=0 b=55", rd1_a, rd1_b);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      we0 = 1'b1; wa0 = 5'd20; wd0 = DATA_W'(i); ra1 = 5'd20; #1;
      vectors++;
      if (rd1_a !== DATA_W'(i) || rd1_b !== exp_rd_b(5'd20)) begin
        miscompares++;
        $display("FAIL back_to_back i=%0d got a=%h b=%h want a=%h b=%h", i, rd1_a, rd1_b, i, exp_rd_b(5'd20));
      end
      step();
    end
    idle_inputs(); ra1 = 5'd20; #1;
    vectors++;
    if (rd1_b !== 32'd4) begin
      miscompares++; $display("FAIL back_to_back_final got %h want 4", rd1_b);
    end
  endtask

  task automatic test_clear_sweep();
    int busy_cnt;
    idle_inputs();
    for (int i = 1; i < DEPTH; i++) begin
      we0 = 1'b1; wa0 = ADDR_W'(i); wd0 = 32'hA5A5_0000 + DATA_W'(i); step();
    end
    idle_inputs(); ra1 = 5'd5; #1;
    vectors++;
    if (rd1_a !== 32'hA5A5_0005) begin
      miscompares++; $display("FAIL fill_read got %h want a5a50005", rd1_a);
    end
    clr_start = 1'b1; step(); clr_start = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      if (busy_a) busy_cnt++;
      vectors++;
      if (busy_a !== (sweep_left > 0) || busy_b !== (sweep_left > 0)) begin
        miscompares++;
        $display("FAIL sweep_busy c=%0d got a=%b b=%b want %b", c, busy_a, busy_b, sweep_left > 0);
      end
      we0 = (c == 10); wa0 = 5'd3; wd0 = 32'h3333_3333; ra1 = ADDR_W'(c); ra2 = 5'd3;
      clr_start = (c == 20); #1;
      vectors++;
      if (rd1_a !== exp_rd_a(ra1) || rd2_a !== exp_rd_a(ra2) || rd1_b !== exp_rd_b(ra1)) begin
        miscompares++;
        $display("FAIL sweep_read c=%0d got %h/%h/%h want %h/%h/%h", c, rd1_a, rd2_a, rd1_b,
                 exp_rd_a(ra1), exp_rd_a(ra2), exp_rd_b(ra1));
      end
      step();
      vectors++;
      if (wr_drop_a !== exp_drop || wr_drop_b !== exp_drop || (c == 10 && wr_drop_a !== 1'b1)) begin
        miscompares++; $display("FAIL sweep_drop c=%0d got a=%b b=%b want %b", c, wr_drop_a, wr_drop_b, exp_drop);
      end
    end
    vectors++;
    if (busy_cnt !== DEPTH) begin
      miscompares++; $display("FAIL sweep_length got %0d want %0d", busy_cnt, DEPTH);
    end
    idle_inputs();
    for (int r = 0; r < DEPTH; r++) begin
      ra1 = ADDR_W'(r); #1;
      vectors++;
      if (rd1_a !== '0 || rd1_b !== '0) begin
        miscompares++; $display("FAIL after_sweep ra=%0d got a=%h b=%h want 0", r, rd1_a, rd1_b);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle_inputs(); we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hCAFE; step();
    idle_inputs(); clr_start = 1'b1; step(); clr_start = 1'b0;
    repeat (10) step();
    reset = 1'b1; step(); reset = 1'b0;
    vectors++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      miscompares++; $display("FAIL abort_busy got a=%b b=%b want 0", busy_a, busy_b);
    end
    for (int r = 0; r < DEPTH; r++) begin
      ra1 = ADDR_W'(r); #1;
      vectors++;
      if (rd1_a !== '0 || rd1_b !== '0) begin
        miscompares++; $display("FAIL abort_read ra=%0d got a=%h b=%h want 0", r, rd1_a, rd1_b);
      end
    end
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99; step();
    we0 = 1'b0; ra1 = 5'd9; #1;
    vectors++;
    if (rd1_a !== 32'h99 || rd1_b !== 32'h99) begin
      miscompares++; $display("FAIL abort_write got a=%h b=%h want 99", rd1_a, rd1_b);
    end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      reset     = ($urandom % 150) == 0;
      clr_start = ($urandom % 40) == 0;
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = ($urandom % 2) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      wa1 = ($urandom % 2) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      ra1 = ($urandom % 2) ? wa0 : ADDR_W'($urandom);
      ra2 = ($urandom % 2) ? wa1 : ADDR_W'($urandom);
      #1;
      vectors++;
      if (rd1_a !== exp_rd_a(ra1) || rd2_a !== exp_rd_a(ra2) ||
          rd1_b !== exp_rd_b(ra1) || rd2_b !== exp_rd_b(ra2)) begin
        miscompares++;
        $display("FAIL rand_read k=%0d got %h/%h/%h/%h want %h/%h/%h/%h", k, rd1_a, rd2_a, rd1_b, rd2_b,
                 exp_rd_a(ra1), exp_rd_a(ra2), exp_rd_b(ra1), exp_rd_b(ra2));
      end
      step();
      vectors++;
      if (busy_a !== (sweep_left > 0) || busy_b !== (sweep_left > 0) ||
          wr_drop_a !== exp_drop || wr_drop_b !== exp_drop ||
          wr_conflict_a !== exp_conf_a || wr_conflict_b !== exp_conf_b) begin
        miscompares++;
        $display("FAIL rand_status k=%0d got %b%b%b %b%b%b want %b%b%b %b%b%b", k,
                 busy_a, wr_drop_a, wr_conflict_a, busy_b, wr_drop_b, wr_conflict_b,
                 sweep_left > 0, exp_drop, exp_conf_a, sweep_left > 0, exp_drop, exp_conf_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_conflict();
    test_back_to_back();
    test_clear_sweep();
    test_reset_mid_sweep();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
